// File: rtl/ram_sdp_be_if.sv
// ram_sdp_be_if: write/read port bundle for ram_sdp_be
// Signals: wen_i/wbe_i/waddr_i/wdata_i (write port), ren_i/raddr_i (read request),
//          rdata_o/rvalid_o (read response); with RAM_SDP_BE_PARITY_EN also
//          perr_inject_i (corrupt parity of written lanes) and perr_o (per-lane parity error).
// Modports: master drives requests, slave is the RAM.
interface ram_sdp_be_if #(
   parameter int DATA_W = 32,
   parameter int BYTE_W = 8,
   parameter int DEPTH  = 256
);
   localparam int NB = DATA_W / BYTE_W;
   localparam int AW = $clog2(DEPTH);
   logic              wen_i;
   logic [NB-1:0]     wbe_i;
   logic [AW-1:0]     waddr_i;
   logic [DATA_W-1:0] wdata_i;
   logic              ren_i;
   logic [AW-1:0]     raddr_i;
   logic [DATA_W-1:0] rdata_o;
   logic              rvalid_o;
`ifdef RAM_SDP_BE_PARITY_EN
   logic              perr_inject_i;
   logic [NB-1:0]     perr_o;
`endif
   modport master (
      output wen_i, wbe_i, waddr_i, wdata_i, ren_i, raddr_i,
`ifdef RAM_SDP_BE_PARITY_EN
      output perr_inject_i,
      input  perr_o,
`endif
      input  rdata_o, rvalid_o
   );
   modport slave (
      input  wen_i, wbe_i, waddr_i, wdata_i, ren_i, raddr_i,
`ifdef RAM_SDP_BE_PARITY_EN
      input  perr_inject_i,
      output perr_o,
`endif
      output rdata_o, rvalid_o
   );
endinterface

// File: rtl/ram_sdp_be.sv
// ram_sdp_be: simple-dual-port RAM with byte enables, 1/2-cycle read pipeline and clear engine
// Ports: clk, rst_n (async, active-low), bus (ram_sdp_be_if.slave: write port, read port,
//        read data/valid), clear_i (start full-array clear), busy_o (clear running, ports blocked).
// Optional macro RAM_SDP_BE_PARITY_EN: per-lane even parity storage, perr_inject_i/perr_o on bus.
module ram_sdp_be #(
   parameter int DATA_W     = 32,
   parameter int BYTE_W     = 8,
   parameter int DEPTH      = 256,
   parameter int RD_LAT     = 1,
   parameter int RDW_MODE   = 0,
   parameter int INIT_CLEAR = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   ram_sdp_be_if.slave bus,
   input  logic        clear_i,
   output logic        busy_o
);
   localparam int NB = DATA_W / BYTE_W;
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);
   localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
   localparam bit CLR_EN = INIT_CLEAR != 0;
   localparam bit FWD_EN = RDW_MODE != 0;

   if (DATA_W % BYTE_W != 0 || !(RD_LAT == 1 || RD_LAT == 2)) begin : g_bad_cfg
      $error("ram_sdp_be: illegal DATA_W/BYTE_W/RD_LAT combination");
   end

   typedef enum logic {CLEAR, READY} state_t;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] ram_q;
   state_t            state_q, state_d;
   logic [AW-1:0]     cnt_q, cnt_d;
   logic              zero_q, zero_d, fwd_q, fwd_d, v1_q, v1_d, v2_q, v2_d;
   logic [NB-1:0]     wbe_q, wbe_d;
   logic [DATA_W-1:0] wdat_q, wdat_d, r2_q, r2_d, d1;
   logic              ready, rd_ok, wr_ok, rd_acc, wr_acc, mem_we;
   logic [AW-1:0]     mem_addr;
   logic [DATA_W-1:0] mem_data;
   logic [NB-1:0]     mem_be;
`ifdef RAM_SDP_BE_PARITY_EN
   logic [NB-1:0]     par_mem [DEPTH];
   logic [NB-1:0]     ram_par_q, wpar_q, wpar_d, perr2_q, perr2_d, mem_par, perr1;
`endif

   always_comb begin
      ready    = state_q == READY;
      rd_ok    = {1'b0, bus.raddr_i} < DEPTH_W;
      wr_ok    = {1'b0, bus.waddr_i} < DEPTH_W;
      // a read issued together with a clear request would complete inside the clear window
      rd_acc   = ready && bus.ren_i && !(CLR_EN && clear_i);
      wr_acc   = ready && bus.wen_i && wr_ok && |bus.wbe_i;
      mem_we   = !ready || wr_acc;
      mem_addr = ready ? bus.waddr_i : cnt_q;
      mem_data = ready ? bus.wdata_i : '0;
      mem_be   = ready ? bus.wbe_i : '1;
      cnt_d    = (ready || clear_i || cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      state_d  = ready ? ((CLR_EN && clear_i) ? CLEAR : READY)
                       : ((!clear_i && cnt_q == LAST) ? READY : CLEAR);
      // zero_q doubles as "nothing valid read yet" so rdata_o starts at 0 without resetting the RAM output
      zero_d   = rd_acc ? !rd_ok : zero_q;
      fwd_d    = rd_acc ? (FWD_EN && wr_acc && bus.waddr_i == bus.raddr_i) : fwd_q;
      wbe_d    = rd_acc ? bus.wbe_i : wbe_q;
      wdat_d   = rd_acc ? bus.wdata_i : wdat_q;
      v1_d     = rd_acc;
      v2_d     = v1_q;
      d1       = '0;
      for (int k = 0; k < NB; k++)
         d1[k*BYTE_W +: BYTE_W] = zero_q ? '0 : (fwd_q && wbe_q[k]) ? wdat_q[k*BYTE_W +: BYTE_W]
                                                                   : ram_q[k*BYTE_W +: BYTE_W];
      r2_d     = v1_q ? d1 : r2_q;
`ifdef RAM_SDP_BE_PARITY_EN
      mem_par  = '0;
      perr1    = '0;
      for (int k = 0; k < NB; k++) begin
         mem_par[k] = ready && ((^bus.wdata_i[k*BYTE_W +: BYTE_W]) ^ bus.perr_inject_i);
         perr1[k]   = !zero_q && ((^d1[k*BYTE_W +: BYTE_W]) ^
                                  ((fwd_q && wbe_q[k]) ? wpar_q[k] : ram_par_q[k]));
      end
      wpar_d   = rd_acc ? mem_par : wpar_q;
      perr2_d  = perr1;
`endif
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k < NB; k++) begin
         if (mem_we && mem_be[k]) begin
            mem[mem_addr][k*BYTE_W +: BYTE_W] <= mem_data[k*BYTE_W +: BYTE_W];
`ifdef RAM_SDP_BE_PARITY_EN
            par_mem[mem_addr][k] <= mem_par[k];
`endif
         end
      end
      if (rd_acc && rd_ok) begin
         ram_q <= mem[bus.raddr_i];
`ifdef RAM_SDP_BE_PARITY_EN
         ram_par_q <= par_mem[bus.raddr_i];
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= CLR_EN ? CLEAR : READY;
         cnt_q   <= '0;
         zero_q  <= 1'b1;
         fwd_q   <= 1'b0;
         wbe_q   <= '0;
         wdat_q  <= '0;
         v1_q    <= 1'b0;
         v2_q    <= 1'b0;
         r2_q    <= '0;
`ifdef RAM_SDP_BE_PARITY_EN
         wpar_q  <= '0;
         perr2_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         zero_q  <= zero_d;
         fwd_q   <= fwd_d;
         wbe_q   <= wbe_d;
         wdat_q  <= wdat_d;
         v1_q    <= v1_d;
         v2_q    <= v2_d;
         r2_q    <= r2_d;
`ifdef RAM_SDP_BE_PARITY_EN
         wpar_q  <= wpar_d;
         perr2_q <= perr2_d;
`endif
      end
   end

   assign bus.rdata_o  = RD_LAT == 2 ? r2_q : d1;
   assign bus.rvalid_o = RD_LAT == 2 ? v2_q : v1_q;
   assign busy_o       = !ready;
`ifdef RAM_SDP_BE_PARITY_EN
   assign bus.perr_o   = bus.rvalid_o ? (RD_LAT == 2 ? perr2_q : perr1) : '0;
`endif
endmodule

// File: tb/tb_ram_sdp_be.sv
// tb_ram_sdp_be: scoreboard bench; dut a = RD_LAT 1/old-data/256 words, dut b = RD_LAT 2/new-data/200 words
module tb_ram_sdp_be;
   typedef struct { logic [31:0] d; logic [3:0] p; int due; } exp_t;
   logic clk = 0, rst_n = 0, clear_i = 0;
   logic wen = 0, ren = 0, inj = 0;
   logic [3:0] wbe = 0;
   logic [7:0] waddr = 0, raddr = 0;
   logic [31:0] wdata = 0;
   logic ba, bb;
   int cyc = 0, nchk = 0, nfail = 0, na, nb;
   exp_t qa[$], qb[$];
   exp_t ea, eb;

   ram_sdp_be_if #(.DEPTH(256)) ia ();
   ram_sdp_be_if #(.DEPTH(200)) ib ();
   assign ia.wen_i = wen;  assign ia.wbe_i = wbe;  assign ia.waddr_i = waddr;
   assign ia.wdata_i = wdata;  assign ia.ren_i = ren;  assign ia.raddr_i = raddr;
   assign ib.wen_i = wen;  assign ib.wbe_i = wbe;  assign ib.waddr_i = waddr;
   assign ib.wdata_i = wdata;  assign ib.ren_i = ren;  assign ib.raddr_i = raddr;
`ifdef RAM_SDP_BE_PARITY_EN
   assign ia.perr_inject_i = inj;
   assign ib.perr_inject_i = inj;
`endif

   ram_sdp_be #(.DEPTH(256), .RD_LAT(1), .RDW_MODE(0)) u_a (.clk(clk), .rst_n(rst_n), .bus(ia), .clear_i(clear_i), .busy_o(ba));
   ram_sdp_be #(.DEPTH(200), .RD_LAT(2), .RDW_MODE(1)) u_b (.clk(clk), .rst_n(rst_n), .bus(ib), .clear_i(clear_i), .busy_o(bb));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endfunction

   always @(negedge clk) if (rst_n) begin
      if (ia.rvalid_o) begin
         if (qa.size() == 0) chk("a_unexpected_rvalid", 1, 0);
         else begin
            ea = qa.pop_front();
            chk("a_rdata", ia.rdata_o, ea.d);
            chk("a_latency", cyc, ea.due);
`ifdef RAM_SDP_BE_PARITY_EN
            chk("a_perr", ia.perr_o, ea.p);
`endif
         end
      end
`ifdef RAM_SDP_BE_PARITY_EN
      else chk("a_perr_idle", ia.perr_o, 0);
`endif
   end

   always @(negedge clk) if (rst_n) begin
      if (ib.rvalid_o) begin
         if (qb.size() == 0) chk("b_unexpected_rvalid", 1, 0);
         else begin
            eb = qb.pop_front();
            chk("b_rdata", ib.rdata_o, eb.d);
            chk("b_latency", cyc, eb.due);
`ifdef RAM_SDP_BE_PARITY_EN
            chk("b_perr", ib.perr_o, eb.p);
`endif
         end
      end
`ifdef RAM_SDP_BE_PARITY_EN
      else chk("b_perr_idle", ib.perr_o, 0);
`endif
   end

   task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
      wen = 1; waddr = a; wdata = d; wbe = be;
      @(negedge clk);
      wen = 0;
   endtask

   task automatic rd(input logic [7:0] a, input logic [31:0] da, input logic [31:0] db, input logic [3:0] p = 4'h0);
      ren = 1; raddr = a;
      qa.push_back('{da, p, cyc + 1});
      qb.push_back('{db, p, cyc + 2});
      @(negedge clk);
      ren = 0;
   endtask

   // counts busy cycles of each dut; with poke, fires a write+read in the middle of the clear
   task automatic wait_idle(input bit poke, output int ca, output int cb);
      ca = 0; cb = 0;
      for (int i = 0; i < 1000 && (ba || bb); i++) begin
         ca += int'(ba); cb += int'(bb);
         if (poke && i == 50) begin
            wen = 1; wbe = 4'hF; waddr = 1; wdata = 32'h55; ren = 1; raddr = 1;
         end else begin
            wen = 0; ren = 0;
         end
         @(negedge clk);
      end
      wen = 0; ren = 0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("a_reset_rdata", ia.rdata_o, 0);
      chk("a_reset_rvalid", ia.rvalid_o, 0);
      chk("a_reset_busy", ba, 1);
      chk("b_reset_rdata", ib.rdata_o, 0);
      chk("b_reset_rvalid", ib.rvalid_o, 0);
      chk("b_reset_busy", bb, 1);
      rst_n = 1;
      wait_idle(0, na, nb);
      chk("a_init_clear_cycles", na, 256);
      chk("b_init_clear_cycles", nb, 200);
      for (int i = 0; i < 256; i++) rd(8'(i), 0, 0);
      wr(5, 32'hAABBCCDD, 4'hF);
      wr(5, 32'h11223344, 4'b0101);
      rd(5, 32'hAA22CC44, 32'hAA22CC44);
      for (int i = 0; i < 4; i++) wr(8'(i), 32'h10 + i, 4'hF);
      for (int i = 0; i < 4; i++) rd(8'(i), 32'h10 + i, 32'h10 + i);
      wr(7, 32'hCAFEF00D, 4'h0);
      rd(7, 0, 0);
      wen = 1; wbe = 4'b0011; waddr = 9; wdata = 32'hFFFFFFFF;
      rd(9, 32'h00000000, 32'h0000FFFF);
      wen = 0;
      rd(9, 32'h0000FFFF, 32'h0000FFFF);
      wr(210, 32'h0000DEAD, 4'hF);
      rd(210, 32'h0000DEAD, 0);
      rd(199, 0, 0);
`ifdef RAM_SDP_BE_PARITY_EN
      wr(20, 32'h12345678, 4'hF);
      inj = 1;
      wr(20, 32'h12345678, 4'b1000);
      inj = 0;
      rd(20, 32'h12345678, 32'h12345678, 4'b1000);
      wr(20, 32'h12345678, 4'hF);
      rd(20, 32'h12345678, 32'h12345678, 4'b0000);
`endif
      repeat (4) @(negedge clk);
      clear_i = 1; ren = 1; raddr = 0;
      @(negedge clk);
      clear_i = 0; ren = 0;
      repeat (100) @(negedge clk);
      clear_i = 1;
      @(negedge clk);
      clear_i = 0;
      wait_idle(1, na, nb);
      chk("a_restart_clear_cycles", na, 256);
      chk("b_restart_clear_cycles", nb, 200);
      rd(1, 0, 0);
      rd(3, 0, 0);
      rd(5, 0, 0);
      repeat (6) @(negedge clk);
      chk("a_queue_empty", qa.size(), 0);
      chk("b_queue_empty", qb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end
endmodule
